// File: rtl/hit_detect.sv
// Trigger-driven hit detection: snapshots the crosshair on a fire edge, box-tests it
// against three enemies, then serialises one pulse per hit (or a miss) before a reload lockout.

module hit_box #(
  parameter int W = 11,
  parameter int R = 16
) (
  input  logic [W-1:0] ex,
  input  logic [W-1:0] ey,
  input  logic [W-1:0] lx,
  input  logic [W-1:0] ly,
  input  logic         alive,
  output logic         match
);
  logic [W:0] dx, dy;

  // Magnitudes are formed one bit wider so screen edges never wrap into a match.
  always_comb begin
    dx    = (ex >= lx) ? ({1'b0, ex} - {1'b0, lx}) : ({1'b0, lx} - {1'b0, ex});
    dy    = (ey >= ly) ? ({1'b0, ey} - {1'b0, ly}) : ({1'b0, ly} - {1'b0, ey});
    match = alive && (dx <= (W+1)'(R)) && (dy <= (W+1)'(R));
  end
endmodule

module hit_detect #(
  parameter int COORD_WIDTH   = 11,
  parameter int HIT_RADIUS    = 16,
  parameter int RELOAD_CYCLES = 1000,
  parameter int SHOT_WIDTH    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fire,
  input  logic [COORD_WIDTH-1:0] cross_x,
  input  logic [COORD_WIDTH-1:0] cross_y,
  input  logic [COORD_WIDTH-1:0] en1_x,
  input  logic [COORD_WIDTH-1:0] en1_y,
  input  logic [COORD_WIDTH-1:0] en2_x,
  input  logic [COORD_WIDTH-1:0] en2_y,
  input  logic [COORD_WIDTH-1:0] en3_x,
  input  logic [COORD_WIDTH-1:0] en3_y,
  input  logic [2:0]             en_alive,
  output logic                   hit1,
  output logic                   hit2,
  output logic                   hit3,
  output logic                   miss,
  output logic                   busy,
  output logic [SHOT_WIDTH-1:0]  shots
);
  localparam int NE = 3;
  localparam int RW = (RELOAD_CYCLES > 0) ? $clog2(RELOAD_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, CHECK, EMIT, RELOAD} state_t;

  state_t                         state, state_n;
  logic [NE-1:0][COORD_WIDTH-1:0] en_x, en_y;
  logic [COORD_WIDTH-1:0]         lx, ly, lx_n, ly_n;
  logic [NE-1:0]                  match, pending, pend_n, hit_q, hit_n;
  logic [RW-1:0]                  rcnt, rcnt_n;
  logic [SHOT_WIDTH-1:0]          shots_n;
  logic                           fire_q, fire_rise, miss_n, last;

  assign en_x      = {en3_x, en2_x, en1_x};
  assign en_y      = {en3_y, en2_y, en1_y};
  assign fire_rise = fire & ~fire_q;
  assign {hit3, hit2, hit1} = hit_q;

  for (genvar k = 0; k < NE; k++) begin : g_box
    hit_box #(.W(COORD_WIDTH), .R(HIT_RADIUS)) u_box (
      .ex(en_x[k]), .ey(en_y[k]), .lx(lx), .ly(ly),
      .alive(en_alive[k]), .match(match[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lx      <= '0;
      ly      <= '0;
      pending <= '0;
      rcnt    <= '0;
      shots   <= '0;
      hit_q   <= '0;
      miss    <= 1'b0;
      busy    <= 1'b0;
      fire_q  <= 1'b1;
    end else begin
      state   <= state_n;
      lx      <= lx_n;
      ly      <= ly_n;
      pending <= pend_n;
      rcnt    <= rcnt_n;
      shots   <= shots_n;
      hit_q   <= hit_n;
      miss    <= miss_n;
      busy    <= (state_n != IDLE);
      fire_q  <= fire;
    end
  end

  always_comb begin
    state_n = state;
    lx_n    = lx;
    ly_n    = ly;
    pend_n  = pending;
    rcnt_n  = rcnt;
    shots_n = shots;
    hit_n   = '0;
    miss_n  = 1'b0;
    last    = 1'b0;
    case (state)
      IDLE: if (fire_rise) begin
        lx_n    = cross_x;
        ly_n    = cross_y;
        if (shots != {SHOT_WIDTH{1'b1}}) shots_n = shots + 1'b1;
        state_n = CHECK;
      end
      CHECK: begin
        pend_n  = match;
        state_n = EMIT;
      end
      EMIT: begin
        if (pending == '0) begin
          miss_n = 1'b1;
          last   = 1'b1;
        end else begin
          // Isolate and retire the lowest pending enemy: fixed 1,2,3 order.
          hit_n  = pending & (~pending + 1'b1);
          pend_n = pending & (pending - 1'b1);
          last   = (pend_n == '0);
        end
        if (last) begin
          if (RELOAD_CYCLES == 0) begin
            state_n = IDLE;
          end else begin
            rcnt_n  = RW'(RELOAD_CYCLES);
            state_n = RELOAD;
          end
        end
      end
      RELOAD: begin
        rcnt_n = rcnt - 1'b1;
        if (rcnt == RW'(1)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_hit_detect.sv
// Bench for hit_detect: a schedule-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized play.

module tb_hit_detect;
  localparam int W  = 11;
  localparam int RL = 1000;
  localparam int MX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         fire = 1'b0, fire2 = 1'b0;
  logic [W-1:0] cross_x = '0, cross_y = '0;
  logic [W-1:0] ex[3], ey[3];
  logic [2:0]   en_alive = '0;
  logic         hit1, hit2, hit3, miss, busy;
  logic [7:0]   shots;
  logic         h2_1, h2_2, h2_3, miss2, busy2;
  logic [1:0]   shots2;

  int n_cmp = 0, n_bad = 0, n_print = 0;

  always #5 clk = ~clk;

  hit_detect #(.COORD_WIDTH(W), .HIT_RADIUS(16), .RELOAD_CYCLES(RL), .SHOT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .fire(fire), .cross_x(cross_x), .cross_y(cross_y),
    .en1_x(ex[0]), .en1_y(ey[0]), .en2_x(ex[1]), .en2_y(ey[1]), .en3_x(ex[2]), .en3_y(ey[2]),
    .en_alive(en_alive), .hit1(hit1), .hit2(hit2), .hit3(hit3), .miss(miss), .busy(busy),
    .shots(shots)
  );

  hit_detect #(.COORD_WIDTH(W), .HIT_RADIUS(16), .RELOAD_CYCLES(0), .SHOT_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .fire(fire2), .cross_x(cross_x), .cross_y(cross_y),
    .en1_x(ex[0]), .en1_y(ey[0]), .en2_x(ex[1]), .en2_y(ey[1]), .en3_x(ex[2]), .en3_y(ey[2]),
    .en_alive(en_alive), .hit1(h2_1), .hit2(h2_2), .hit3(h2_3), .miss(miss2), .busy(busy2),
    .shots(shots2)
  );

  // Reference model: each accepted shot becomes a schedule of pulses keyed by cycle number.
  int         cyc = 0;
  int         idle_e = -1, chk_e = -1;
  logic       fire_prev = 1'b1;
  int         m_lx, m_ly, m_shots = 0;
  logic [2:0] hsched[int];
  bit         msched[int];

  function automatic int absd(int a, int b);
    return (a > b) ? a - b : b - a;
  endfunction

  always @(posedge clk) begin
    int n;
    cyc++;
    if (!rst_n) begin
      fire_prev = 1'b1; m_shots = 0; idle_e = -1; chk_e = -1;
      hsched.delete(); msched.delete();
    end else begin
      if (cyc == chk_e) begin
        n = 0;
        for (int k = 0; k < 3; k++)
          if (en_alive[k] && absd(int'(ex[k]), m_lx) <= 16 && absd(int'(ey[k]), m_ly) <= 16) begin
            hsched[cyc + 1 + n] = 3'(1 << k);
            n++;
          end
        if (n == 0) begin
          msched[cyc + 1] = 1'b1;
          n = 1;
        end
        idle_e = cyc + n + RL;
      end
      if (cyc > idle_e && fire && !fire_prev) begin
        m_lx = int'(cross_x); m_ly = int'(cross_y);
        if (m_shots < 255) m_shots++;
        idle_e = 32'h3fff_ffff;
        chk_e  = cyc + 1;
      end
      fire_prev = fire;
    end
  end

  always @(negedge clk) begin
    logic [2:0] eh; logic em, eb; logic [7:0] es;
    if (!rst_n) begin
      eh = '0; em = 1'b0; eb = 1'b0; es = '0;
    end else begin
      eh = hsched.exists(cyc) ? hsched[cyc] : 3'b0;
      em = msched.exists(cyc);
      eb = (cyc < idle_e);
      es = 8'(m_shots);
    end
    n_cmp++;
    if ({hit3, hit2, hit1, miss, busy, shots} !== {eh, em, eb, es}) begin
      n_bad++;
      if (n_print < 20) begin
        n_print++;
        $display("FAIL model cyc%0d: got hit=%b miss=%b busy=%b shots=%0d, want hit=%b miss=%b busy=%b shots=%0d",
                 cyc, {hit3, hit2, hit1}, miss, busy, shots, eh, em, eb, es);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 1500 && busy; i++) tick();
    if (busy) chk({name, "_timeout"}, 1, 0);
  endtask

  // Fires from idle; returns busy length and {miss,hit3,hit2,hit1} after E2..E5.
  task automatic shot(output int blen, output logic [3:0] p0, output logic [3:0] p1,
                      output logic [3:0] p2, output logic [3:0] p3);
    logic [3:0] pat[4];
    pat  = '{default: 4'b0};
    blen = -1;
    fire = 1'b1;
    for (int i = 1; i <= 1500; i++) begin
      tick();
      if (i == 2) fire = 1'b0;
      if (i >= 3 && i <= 6) pat[i-3] = {miss, hit3, hit2, hit1};
      if (!busy) begin
        blen = i - 1;
        break;
      end
    end
    p0 = pat[0]; p1 = pat[1]; p2 = pat[2]; p3 = pat[3];
  endtask

  task automatic place(input int k, input int x, input int y);
    ex[k] = W'(x); ey[k] = W'(y);
  endtask

  function automatic logic [W-1:0] cl(input int v);
    if (v < 0) return '0;
    if (v > MX) return W'(MX);
    return W'(v);
  endfunction

  initial begin
    int blen, h;
    logic [3:0] p0, p1, p2, p3;
    for (int k = 0; k < 3; k++) place(k, 0, 0);
    #1 rst_n = 1'b0;

    // 1: trigger held through reset does not fire
    fire = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(4);
    chk("t1_shots", shots, 0);
    chk("t1_busy", busy, 0);
    fire = 1'b0;
    tick();

    // 2: single hit, latency and reload length
    cross_x = 100; cross_y = 100; place(0, 110, 90); en_alive = 3'b001;
    shot(blen, p0, p1, p2, p3);
    chk("t2_pulse", p0, 4'b0001);
    chk("t2_after", p1, 4'b0000);
    chk("t2_busylen", blen, 1002);
    chk("t2_shots", shots, 1);

    // 3: three overlapping enemies, dy exactly at radius
    for (int k = 0; k < 3; k++) place(k, 200, 200);
    cross_x = 200; cross_y = 216; en_alive = 3'b111;
    tick();
    shot(blen, p0, p1, p2, p3);
    chk("t3_p0", p0, 4'b0001);
    chk("t3_p1", p1, 4'b0010);
    chk("t3_p2", p2, 4'b0100);
    chk("t3_p3", p3, 4'b0000);
    chk("t3_busylen", blen, 1004);

    // 4: just outside radius plus a dead enemy on target -> miss
    cross_x = 100; cross_y = 100; place(0, 117, 100); place(1, 100, 100); place(2, 900, 900);
    en_alive = 3'b101;
    tick();
    shot(blen, p0, p1, p2, p3);
    chk("t4_p0", p0, 4'b1000);
    chk("t4_p1", p1, 4'b0000);
    chk("t4_shots", shots, 3);

    // 7: screen-edge coordinates do not wrap; corner of the box is inclusive
    cross_x = 0; cross_y = 0; place(0, MX, 0); place(1, 0, MX); place(2, 16, 16);
    en_alive = 3'b111;
    tick();
    shot(blen, p0, p1, p2, p3);
    chk("t7_p0", p0, 4'b0100);
    chk("t7_p1", p1, 4'b0000);

    // 5: fire edges during reload are discarded
    tick();
    fire = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (i > 5) fire = i[0];
    end
    fire = 1'b0;
    tick();
    chk("t5_shots_reload", shots, 5);
    chk("t5_busy", busy, 1);
    wait_idle("t5");
    tick();
    shot(blen, p0, p1, p2, p3);
    chk("t5_shots_after", shots, 6);

    // 6: reset in EMIT with two enemies pending
    cross_x = 300; cross_y = 300; place(0, 300, 300); place(1, 305, 295); place(2, 0, 0);
    en_alive = 3'b011;
    tick();
    fire = 1'b1;
    tick(2);
    #1 rst_n = 1'b0;
    #1 chk("t6_outs", {hit3, hit2, hit1, miss, busy, shots}, 0);
    tick(2);
    rst_n = 1'b1;
    fire = 1'b0;
    h = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      h += int'(hit1) + int'(hit2) + int'(hit3) + int'(miss);
    end
    chk("t6_no_pulses", h, 0);

    // Saturating 2-bit shot counter, no lockout, three hits per shot
    for (int k = 0; k < 3; k++) place(k, 500, 500);
    cross_x = 500; cross_y = 500; en_alive = 3'b111;
    h = 0;
    for (int s = 1; s <= 5; s++) begin
      fire2 = 1'b1;
      tick();
      fire2 = 1'b0;
      for (int i = 0; i < 4; i++) begin
        tick();
        h += int'(h2_1) + int'(h2_2) + int'(h2_3) + int'(miss2);
      end
      chk("sat_shots", shots2, (s > 3) ? 3 : s);
    end
    chk("sat_hits", h, 15);
    chk("sat_busy", busy2, 0);

    // Randomized play against the model
    for (int i = 0; i < 24000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        int r, bx, by;
        r  = int'($urandom_range(0, 7));
        bx = (r == 0) ? 0 : (r == 1) ? MX : int'($urandom_range(0, MX));
        by = (r == 2) ? 0 : (r == 3) ? MX : int'($urandom_range(0, MX));
        cross_x = cl(bx + int'($urandom_range(0, 40)) - 20);
        cross_y = cl(by + int'($urandom_range(0, 40)) - 20);
        for (int k = 0; k < 3; k++) begin
          ex[k] = cl(bx + int'($urandom_range(0, 48)) - 24);
          ey[k] = cl(by + int'($urandom_range(0, 48)) - 24);
        end
        en_alive = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 3) == 0) fire = ~fire;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
